// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: lets NREQ display fields share one dual2bcd converter.
// Requests are served round-robin. The winner's binary operand is latched at
// grant and sent to the converter with a one-cycle start pulse. The BCD result
// goes back to the winner together with a one-cycle one-hot done pulse.
// The converter must be reset by the same synchronous active-low reset.
//
// Build option: define ARB_TIMEOUT_EN to add a WAIT-state watchdog. After
// TIMEOUT_CYC cycles without conv_finish it pulses err together with done[g],
// returns all-ones as the result and moves on. In the default build err is
// tied low and WAIT waits indefinitely.
module bcd_conv_arbiter #(
    parameter int  NREQ        = 4,
    parameter int  DUALW       = 14,
    parameter int  BCDW        = 16,
    parameter int  TIMEOUT_CYC = 64,
    localparam int IDXW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DUALW-1:0] req_dual,
    output logic [NREQ-1:0]       done,
    output logic [BCDW-1:0]       res_bcd,
    output logic                  busy,
    output logic [IDXW-1:0]       grant_idx,
    output logic                  conv_start,
    output logic [DUALW-1:0]      conv_dual,
    input  logic                  conv_finish,
    input  logic [BCDW-1:0]       conv_bcd,
    output logic                  err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [IDXW-1:0]   rr_ptr_r;
    logic [IDXW-1:0]   rr_ptr_s;
    logic [IDXW:0]     pick_s;
    logic              pick_found_s;
    logic [IDXW-1:0]   pick_idx_s;
    logic [IDXW-1:0]   next_ptr_s;
    logic [NREQ-1:0]   grant_onehot_s;
    logic [IDXW-1:0]   grant_idx_s;
    logic [DUALW-1:0]  conv_dual_s;
    logic [BCDW-1:0]   res_bcd_s;
    logic              busy_s;
    logic              conv_start_s;
    logic [NREQ-1:0]   done_s;

`ifdef ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT_CYC + 1);
    logic [CNTW-1:0]   wait_cnt_r;
    logic [CNTW-1:0]   wait_cnt_s;
    logic              err_s;
`endif

    // Round-robin search: the first set request at or above ptr, wrapping.
    // Returns {found, index}.
    function automatic logic [IDXW:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IDXW-1:0] p);
        logic [IDXW:0] res;
        int            j;
        res = {(IDXW + 1){1'b0}};
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(p) + k) % NREQ;
            if (r[j]) begin
                res = {1'b1, IDXW'(j)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Winner of the current request vector, relative to the round-robin pointer.
    always_comb begin
        pick_s = rr_pick(req, rr_ptr_r);
    end

    assign pick_found_s   = pick_s[IDXW];
    assign pick_idx_s     = pick_s[IDXW-1:0];
    assign grant_onehot_s = {{(NREQ - 1){1'b0}}, 1'b1} << grant_idx;

    // Pointer value that puts the granted requester last in line.
    always_comb begin
        if (grant_idx == IDXW'(NREQ - 1)) begin
            next_ptr_s = {IDXW{1'b0}};
        end else begin
            next_ptr_s = grant_idx + IDXW'(1);
        end
    end

    // Next-state and next-output logic for the IDLE/START/WAIT sequence.
    always_comb begin
        state_s      = state_r;
        rr_ptr_s     = rr_ptr_r;
        grant_idx_s  = grant_idx;
        conv_dual_s  = conv_dual;
        res_bcd_s    = res_bcd;
        busy_s       = busy;
        conv_start_s = 1'b0;
        done_s       = {NREQ{1'b0}};
`ifdef ARB_TIMEOUT_EN
        wait_cnt_s   = wait_cnt_r;
        err_s        = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    // The operand is captured here, so later req_dual changes
                    // cannot disturb the running conversion.
                    grant_idx_s = pick_idx_s;
                    conv_dual_s = req_dual[int'(pick_idx_s) * DUALW +: DUALW];
                    busy_s      = 1'b1;
                    state_s     = ST_START;
                end else begin
                    busy_s      = 1'b0;
                end
            end
            ST_START: begin
                conv_start_s = 1'b1;
                state_s      = ST_WAIT;
`ifdef ARB_TIMEOUT_EN
                wait_cnt_s   = {CNTW{1'b0}};
`endif
            end
            ST_WAIT: begin
                if (conv_finish) begin
                    res_bcd_s = conv_bcd;
                    done_s    = grant_onehot_s;
                    rr_ptr_s  = next_ptr_s;
                    state_s   = ST_IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (wait_cnt_r == CNTW'(TIMEOUT_CYC - 1)) begin
                    res_bcd_s = {BCDW{1'b1}};
                    done_s    = grant_onehot_s;
                    err_s     = 1'b1;
                    rr_ptr_s  = next_ptr_s;
                    state_s   = ST_IDLE;
                end else begin
                    wait_cnt_s = wait_cnt_r + CNTW'(1);
                end
`else
                else begin
                    state_s = ST_WAIT;
                end
`endif
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, pointer and registered outputs; reset drops any conversion in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= {IDXW{1'b0}};
            grant_idx  <= {IDXW{1'b0}};
            conv_dual  <= {DUALW{1'b0}};
            res_bcd    <= {BCDW{1'b0}};
            busy       <= 1'b0;
            conv_start <= 1'b0;
            done       <= {NREQ{1'b0}};
        end else begin
            state_r    <= state_s;
            rr_ptr_r   <= rr_ptr_s;
            grant_idx  <= grant_idx_s;
            conv_dual  <= conv_dual_s;
            res_bcd    <= res_bcd_s;
            busy       <= busy_s;
            conv_start <= conv_start_s;
            done       <= done_s;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog counter and error pulse register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wait_cnt_r <= {CNTW{1'b0}};
            err        <= 1'b0;
        end else begin
            wait_cnt_r <= wait_cnt_s;
            err        <= err_s;
        end
    end
`else
    // Without the watchdog the timeout limit has no consumer.
    logic unused_timeout_s;
    assign unused_timeout_s = ^(32'(TIMEOUT_CYC));
    assign err              = 1'b0;
`endif

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Shares one dual2bcd converter instance among NREQ requesters (e.g. speed, distance, avg_speed, time fields) using round-robin arbitration.
- Accepts a binary value and a request from each client and drives the converter's start/dual inputs.
- Collects the converter's finish/bcd outputs and returns the result to the granted client with a one-cycle done pulse.
- Sits between the display-field logic and a single dual2bcd #(DUALW, BCDW), so the display pipeline needs one converter instead of several.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DUALW, 14, binary value width per requester and converter input width.
- BCDW, 16, converter BCD output width.
- TIMEOUT_CYC, 64, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  NREQ  per-requester request level; held high until that requester's done.
- req_dual  in  NREQ*DUALW  packed values; requester i occupies bits [i*DUALW +: DUALW].
- done  out  NREQ  one-hot, one-cycle completion pulse.
- res_bcd  out  BCDW  result; valid in the done cycle and held until the next done.
- busy  out  1  high from grant until the done cycle inclusive.
- grant_idx  out  clog2(NREQ)  index of the current or last granted requester.
- conv_start  out  1  one-cycle start pulse to the converter.
- conv_dual  out  DUALW  operand to the converter; stable from conv_start until finish.
- conv_finish  in  1  converter finish pulse.
- conv_bcd  in  BCDW  converter result, sampled when conv_finish is high.
- err  out  1  timeout pulse; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (reset==0 at a rising edge):
  - State goes to IDLE and the round-robin pointer rr_ptr goes to 0.
  - done, conv_start, busy and err are 0; res_bcd, conv_dual and grant_idx are 0.
  - Reset has priority over every other event, including mid-conversion. An in-flight conversion is abandoned and no done is issued.
  - The converter must share the same reset.
- States are IDLE, START and WAIT.
- IDLE:
  - If any req bit is high, search from rr_ptr upward, wrapping modulo NREQ; the first set bit wins (index g).
  - Register grant_idx=g, conv_dual=req_dual[g], busy=1, then go to START.
  - If no req bit is high, stay in IDLE.
- START:
  - conv_start=1 for exactly this cycle; go to WAIT.
  - Grant-to-start latency is 1 cycle after the req is sampled.
- WAIT:
  - conv_start=0. On conv_finish==1: res_bcd<=conv_bcd, done[g]<=1 for one cycle, rr_ptr<=(g+1) mod NREQ, then go to IDLE.
  - busy stays high through the done cycle and drops the next cycle.
- Done latency: done rises the cycle after conv_finish.
- Back-to-back: the next grant is evaluated in the IDLE cycle after done, so the next conv_start comes 2 cycles after done.
- req_dual is sampled only at grant. Later changes to the value have no effect on the running conversion.
- If req[g] drops during START or WAIT, the conversion still completes and done[g] still pulses.
- conv_finish in IDLE or START is ignored.
- A requester that still holds req after its done is eligible again, but only in rr_ptr order. With all requesters active, each is served once per NREQ conversions (no starvation).
- res_bcd is never cleared except by reset.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT.
  - If it reaches TIMEOUT_CYC without conv_finish:
    - err pulses for 1 cycle together with done[g];
    - res_bcd is set to all ones;
    - rr_ptr advances and the state returns to IDLE.
  - The counter clears on entering WAIT.
- Not defined: no counter exists, err is constant 0, and WAIT waits indefinitely.

Test Plan:
- Bench converter model asserts finish 16 cycles after start.
- Reset, then req=0001, req_dual[0]=14'd1234:
  - conv_start at cycle 2 with conv_dual=1234;
  - done=0001 with res_bcd=16'h1234 one cycle after finish;
  - busy high from cycle 1 through the done cycle.
- req=1111 held continuously with values 10, 20, 30, 40:
  - grant order 0, 1, 2, 3, 0;
  - results 16'h0010, 16'h0020, 16'h0030, 16'h0040;
  - conv_start spacing is 16+3 cycles.
- req=0100 granted with value 9999, then req_dual changed to 5 and req dropped during WAIT:
  - done=0100 still pulses with res_bcd=16'h9999.
- Assert reset 5 cycles into WAIT, then release with req=0010, value 77:
  - no done for the aborted conversion;
  - grant_idx=1 and result 16'h0077.
- ARB_TIMEOUT_EN with TIMEOUT_CYC=64 and the model never asserting finish:
  - err and done[g] pulse together at WAIT cycle 64 with res_bcd=16'hFFFF;
  - the next requester is then granted.
